// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bit-reversal reorder buffer:
// default sizes, a complex-sample type and the bit-reversal permutation.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int LOG2_N_DEF     = 3;
  localparam int BITREV_MAX     = 12;

  // One complex sample, real word in the upper half.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] re;
    logic [DATA_WIDTH_DEF-1:0] im;
  } cplx_t;

  // Reverse the low 'width' bits of 'value'. With a constant width this is
  // only a rewiring of the count bits.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] value,
                                                   input int unsigned width);
    logic [BITREV_MAX-1:0] rev;
    rev = {<<{value}};
    return rev >> (BITREV_MAX - width);
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One frame bank: simple dual-port RAM, synchronous write, asynchronous read.
module fft_bank_ram
  import fft_pkg::*;
#(
  parameter int WIDTH      = 2 * DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = LOG2_N_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: frames are written in natural order into one bank
// while the other bank drains in bit-reversed order through a registered
// output stage.
// Optional macro FFT_BITREV_FRAME_CHECK_EN adds in_last framing input and a
// sticky frame_err output; an early in_last closes the frame immediately.
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG2_N     = LOG2_N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
`ifdef FFT_BITREV_FRAME_CHECK_EN
  input  logic                  in_last,
  output logic                  frame_err,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [LOG2_N-1:0]     out_idx,
  output logic                  out_last
);

  localparam int                N        = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_CNT = LOG2_N'(N - 1);

  logic [LOG2_N-1:0]       wr_cnt;
  logic [LOG2_N-1:0]       rd_cnt;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [1:0]              full;
  logic                    ready_en;
  logic                    wr_fire;
  logic                    wr_end;
  logic                    load;
  logic                    rd_end;
  logic [LOG2_N-1:0]       rd_addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [2*DATA_WIDTH-1:0] rdata0;
  logic [2*DATA_WIDTH-1:0] rdata1;
  logic [2*DATA_WIDTH-1:0] rd_word;

  assign in_ready = ready_en && !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
`ifdef FFT_BITREV_FRAME_CHECK_EN
  assign wr_end   = (wr_cnt == LAST_CNT) || in_last;
`else
  assign wr_end   = (wr_cnt == LAST_CNT);
`endif
  assign wdata    = {in_r, in_i};

  assign rd_end   = (rd_cnt == LAST_CNT);
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign rd_addr  = LOG2_N'(bitrev(BITREV_MAX'(rd_cnt), LOG2_N));
  assign rd_word  = rd_bank ? rdata1 : rdata0;

  fft_bank_ram #(.WIDTH(2 * DATA_WIDTH), .ADDR_WIDTH(LOG2_N)) u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !wr_bank),
    .waddr (wr_cnt),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  fft_bank_ram #(.WIDTH(2 * DATA_WIDTH), .ADDR_WIDTH(LOG2_N)) u_bank1 (
    .clk   (clk),
    .we    (wr_fire && wr_bank),
    .waddr (wr_cnt),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  // Write side: count samples into the current bank and switch banks at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) begin
        if (wr_end) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Bank full flags: the writer sets one, the reader clears the other; both may act together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_fire && wr_end) begin
        full[wr_bank] <= 1'b1;
      end
      if (load && rd_end) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read side: registered output stage fed in bit-reversed order from the full bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_r     <= rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
      out_i     <= rd_word[DATA_WIDTH-1:0];
      out_idx   <= rd_addr;
      out_last  <= rd_end;
      if (rd_end) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FFT_BITREV_FRAME_CHECK_EN
  // Sticky flag for any accepted sample whose in_last disagrees with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (wr_fire && (in_last != (wr_cnt == LAST_CNT))) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Directed bench for fft_bitrev_buffer: instance a (N=8), b (N=2), c (N=16).
// Optional macro FFT_BITREV_FRAME_CHECK_EN enables the framing-error test.
module tb_fft_bitrev_buffer;

  typedef struct {
    logic [63:0] r;
    logic [63:0] i;
    int          idx;
    logic        last;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_r;
  logic [63:0] in_i;
  logic        out_ready;
  logic        in_valid_a, in_valid_b, in_valid_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [63:0] out_r_a, out_r_b, out_r_c;
  logic [63:0] out_i_a, out_i_b, out_i_c;
  logic [2:0]  out_idx_a;
  logic [0:0]  out_idx_b;
  logic [3:0]  out_idx_c;
  logic        out_last_a, out_last_b, out_last_c;
`ifdef FFT_BITREV_FRAME_CHECK_EN
  logic        in_last_a, in_last_b, in_last_c;
  logic        frame_err_a, frame_err_b, frame_err_c;
  int          last_pos = 7;
  int          wr_pos_a = 0;
  int          wr_pos_b = 0;
  int          wr_pos_c = 0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_a = 0;
  int   last_wr_cyc = 0;
  rec_t rec;
  rec_t qa[$];
  rec_t qb[$];
  rec_t qc[$];
  int   br8[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   br16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_bitrev_buffer #(.DATA_WIDTH(64), .LOG2_N(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_r(in_r), .in_i(in_i),
`ifdef FFT_BITREV_FRAME_CHECK_EN
    .in_last(in_last_a), .frame_err(frame_err_a),
`endif
    .out_valid(out_valid_a), .out_ready(out_ready), .out_r(out_r_a), .out_i(out_i_a),
    .out_idx(out_idx_a), .out_last(out_last_a)
  );

  fft_bitrev_buffer #(.DATA_WIDTH(64), .LOG2_N(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_r(in_r), .in_i(in_i),
`ifdef FFT_BITREV_FRAME_CHECK_EN
    .in_last(in_last_b), .frame_err(frame_err_b),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready), .out_r(out_r_b), .out_i(out_i_b),
    .out_idx(out_idx_b), .out_last(out_last_b)
  );

  fft_bitrev_buffer #(.DATA_WIDTH(64), .LOG2_N(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_r(in_r), .in_i(in_i),
`ifdef FFT_BITREV_FRAME_CHECK_EN
    .in_last(in_last_c), .frame_err(frame_err_c),
`endif
    .out_valid(out_valid_c), .out_ready(out_ready), .out_r(out_r_c), .out_i(out_i_c),
    .out_idx(out_idx_c), .out_last(out_last_c)
  );

  always #5 clk = ~clk;

  // Count rising edges so output timing can be measured.
  always @(posedge clk) cyc++;

`ifdef FFT_BITREV_FRAME_CHECK_EN
  assign in_last_a = (wr_pos_a == last_pos);
  assign in_last_b = (wr_pos_b == 1);
  assign in_last_c = (wr_pos_c == 15);
`endif

  // Record every handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (out_valid_a && out_ready) begin
      rec.r = out_r_a; rec.i = out_i_a; rec.idx = int'(out_idx_a);
      rec.last = out_last_a; rec.cyc = cyc;
      qa.push_back(rec);
    end
    if (out_valid_b && out_ready) begin
      rec.r = out_r_b; rec.i = out_i_b; rec.idx = int'(out_idx_b);
      rec.last = out_last_b; rec.cyc = cyc;
      qb.push_back(rec);
    end
    if (out_valid_c && out_ready) begin
      rec.r = out_r_c; rec.i = out_i_c; rec.idx = int'(out_idx_c);
      rec.last = out_last_c; rec.cyc = cyc;
      qc.push_back(rec);
    end
    if (in_valid_a && in_ready_a) begin
      acc_a++;
      last_wr_cyc = cyc + 1;
    end
`ifdef FFT_BITREV_FRAME_CHECK_EN
    if (!rst_n) begin
      wr_pos_a = 0; wr_pos_b = 0; wr_pos_c = 0;
    end else begin
      if (in_valid_a && in_ready_a) wr_pos_a = in_last_a ? 0 : wr_pos_a + 1;
      if (in_valid_b && in_ready_b) wr_pos_b = in_last_b ? 0 : wr_pos_b + 1;
      if (in_valid_c && in_ready_c) wr_pos_c = in_last_c ? 0 : wr_pos_c + 1;
    end
`endif
  end

  function automatic logic cur_ready(input int which);
    return (which == 0) ? in_ready_a : (which == 1) ? in_ready_b : in_ready_c;
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
  endfunction

  task automatic applyStimulus(input int which, input logic [63:0] base, input int count);
    for (int k = 0; k < count; k++) begin
      int guard;
      guard = 0;
      in_r = base + 64'(k);
      in_i = in_r + 64'd100;
      in_valid_a = (which == 0);
      in_valid_b = (which == 1);
      in_valid_c = (which == 2);
      while (!cur_ready(which) && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) begin
        checks++; errors++;
        $display("[TB] FAIL feed_timeout inst %0d sample %0d got no in_ready want in_ready=1", which, k);
      end
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
  endtask

  task automatic wait_outputs(input int which, input int n, input int budget);
    int waited;
    waited = 0;
    while (qsize(which) < n && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid_a); end
    checks++; if (out_r_a !== 64'd0) begin errors++; $display("[TB] FAIL reset_out_r got %0d want 0", out_r_a); end
    checks++; if (out_i_a !== 64'd0) begin errors++; $display("[TB] FAIL reset_out_i got %0d want 0", out_i_a); end
    checks++; if (out_idx_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_idx got %0d want 0", out_idx_a); end
    checks++; if (out_last_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %0b want 0", out_last_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_a got %0b want 1", in_ready_a); end
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_b got %0b want 1", in_ready_b); end
    checks++; if (in_ready_c !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_c got %0b want 1", in_ready_c); end
  endtask

  task automatic test_basic_order();
    qa.delete();
    applyStimulus(0, 64'd0, 8);
    wait_outputs(0, 8, 40);
    checks++; if (qa.size() != 8) begin errors++; $display("[TB] FAIL basic_count got %0d want 8", qa.size()); end
    for (int k = 0; k < 8 && k < qa.size(); k++) begin
      checks++; if (qa[k].r !== 64'(br8[k])) begin errors++; $display("[TB] FAIL basic_r[%0d] got %0d want %0d", k, qa[k].r, br8[k]); end
      checks++; if (qa[k].i !== 64'(br8[k] + 100)) begin errors++; $display("[TB] FAIL basic_i[%0d] got %0d want %0d", k, qa[k].i, br8[k] + 100); end
      checks++; if (qa[k].idx != br8[k]) begin errors++; $display("[TB] FAIL basic_idx[%0d] got %0d want %0d", k, qa[k].idx, br8[k]); end
      checks++; if (qa[k].last !== (k == 7)) begin errors++; $display("[TB] FAIL basic_last[%0d] got %0b want %0b", k, qa[k].last, k == 7); end
    end
    if (qa.size() > 0) begin
      checks++; if (qa[0].cyc - last_wr_cyc != 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want 1", qa[0].cyc - last_wr_cyc); end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    qa.delete();
    t0 = cyc;
    applyStimulus(0, 64'd200, 24);
    checks++; if (cyc - t0 != 24) begin errors++; $display("[TB] FAIL b2b_input_cycles got %0d want 24", cyc - t0); end
    wait_outputs(0, 24, 80);
    checks++; if (qa.size() != 24) begin errors++; $display("[TB] FAIL b2b_count got %0d want 24", qa.size()); end
    for (int k = 0; k < 24 && k < qa.size(); k++) begin
      checks++; if (qa[k].r !== 64'(200 + (k / 8) * 8 + br8[k % 8])) begin errors++; $display("[TB] FAIL b2b_r[%0d] got %0d want %0d", k, qa[k].r, 200 + (k / 8) * 8 + br8[k % 8]); end
      checks++; if (qa[k].cyc != qa[0].cyc + k) begin errors++; $display("[TB] FAIL b2b_gap[%0d] got cycle %0d want %0d", k, qa[k].cyc, qa[0].cyc + k); end
      checks++; if (qa[k].last !== (k % 8 == 7)) begin errors++; $display("[TB] FAIL b2b_last[%0d] got %0b want %0b", k, qa[k].last, k % 8 == 7); end
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    qa.delete();
    out_ready = 1'b0;
    acc0 = acc_a;
    in_valid_a = 1'b1;
    for (int n = 0; n < 20; n++) begin
      in_r = 64'd300 + 64'(acc_a - acc0);
      in_i = in_r + 64'd100;
      @(posedge clk); #1;
      if (n == 12) begin
        checks++; if (out_r_a !== 64'd300) begin errors++; $display("[TB] FAIL hold_mid_r got %0d want 300", out_r_a); end
      end
    end
    in_valid_a = 1'b0;
    checks++; if (acc_a - acc0 != 16) begin errors++; $display("[TB] FAIL bp_accepts got %0d want 16", acc_a - acc0); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready_a); end
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid got %0b want 1", out_valid_a); end
    checks++; if (out_r_a !== 64'd300) begin errors++; $display("[TB] FAIL hold_r got %0d want 300", out_r_a); end
    checks++; if (out_i_a !== 64'd400) begin errors++; $display("[TB] FAIL hold_i got %0d want 400", out_i_a); end
    checks++; if (out_idx_a !== 3'd0) begin errors++; $display("[TB] FAIL hold_idx got %0d want 0", out_idx_a); end
    checks++; if (out_last_a !== 1'b0) begin errors++; $display("[TB] FAIL hold_last got %0b want 0", out_last_a); end
    checks++; if (qa.size() != 0) begin errors++; $display("[TB] FAIL hold_no_transfer got %0d want 0", qa.size()); end
    out_ready = 1'b1;
    wait_outputs(0, 16, 60);
    checks++; if (qa.size() != 16) begin errors++; $display("[TB] FAIL bp_count got %0d want 16", qa.size()); end
    for (int k = 0; k < 16 && k < qa.size(); k++) begin
      checks++; if (qa[k].r !== 64'(300 + (k / 8) * 8 + br8[k % 8])) begin errors++; $display("[TB] FAIL bp_r[%0d] got %0d want %0d", k, qa[k].r, 300 + (k / 8) * 8 + br8[k % 8]); end
      checks++; if (qa[k].i !== 64'(400 + (k / 8) * 8 + br8[k % 8])) begin errors++; $display("[TB] FAIL bp_i[%0d] got %0d want %0d", k, qa[k].i, 400 + (k / 8) * 8 + br8[k % 8]); end
    end
  endtask

  task automatic test_reset_midframe();
    qa.delete();
    out_ready = 1'b1;
    applyStimulus(0, 64'd400, 13);
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid got %0b want 1", out_valid_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %0b want 0", out_valid_a); end
    checks++; if (out_r_a !== 64'd0) begin errors++; $display("[TB] FAIL midrst_r got %0d want 0", out_r_a); end
    checks++; if (out_i_a !== 64'd0) begin errors++; $display("[TB] FAIL midrst_i got %0d want 0", out_i_a); end
    checks++; if (out_idx_a !== 3'd0) begin errors++; $display("[TB] FAIL midrst_idx got %0d want 0", out_idx_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    qa.delete();
    applyStimulus(0, 64'd500, 8);
    wait_outputs(0, 8, 40);
    checks++; if (qa.size() != 8) begin errors++; $display("[TB] FAIL midrst_count got %0d want 8", qa.size()); end
    for (int k = 0; k < 8 && k < qa.size(); k++) begin
      checks++; if (qa[k].r !== 64'(500 + br8[k])) begin errors++; $display("[TB] FAIL midrst_r[%0d] got %0d want %0d", k, qa[k].r, 500 + br8[k]); end
      checks++; if (qa[k].last !== (k == 7)) begin errors++; $display("[TB] FAIL midrst_last[%0d] got %0b want %0b", k, qa[k].last, k == 7); end
    end
  endtask

  task automatic test_small_sizes();
    qb.delete();
    qc.delete();
    applyStimulus(1, 64'd7, 1);
    applyStimulus(1, 64'd9, 1);
    wait_outputs(1, 2, 20);
    checks++; if (qb.size() != 2) begin errors++; $display("[TB] FAIL n2_count got %0d want 2", qb.size()); end
    if (qb.size() == 2) begin
      checks++; if (qb[0].r !== 64'd7) begin errors++; $display("[TB] FAIL n2_r0 got %0d want 7", qb[0].r); end
      checks++; if (qb[1].r !== 64'd9) begin errors++; $display("[TB] FAIL n2_r1 got %0d want 9", qb[1].r); end
      checks++; if (qb[1].i !== 64'd109) begin errors++; $display("[TB] FAIL n2_i1 got %0d want 109", qb[1].i); end
      checks++; if (qb[1].idx != 1) begin errors++; $display("[TB] FAIL n2_idx1 got %0d want 1", qb[1].idx); end
      checks++; if (qb[0].last !== 1'b0 || qb[1].last !== 1'b1) begin errors++; $display("[TB] FAIL n2_last got %0b%0b want 01", qb[0].last, qb[1].last); end
    end
    applyStimulus(2, 64'd0, 16);
    wait_outputs(2, 16, 60);
    checks++; if (qc.size() != 16) begin errors++; $display("[TB] FAIL n16_count got %0d want 16", qc.size()); end
    for (int k = 0; k < 16 && k < qc.size(); k++) begin
      checks++; if (qc[k].r !== 64'(br16[k])) begin errors++; $display("[TB] FAIL n16_r[%0d] got %0d want %0d", k, qc[k].r, br16[k]); end
      checks++; if (qc[k].i !== 64'(br16[k] + 100)) begin errors++; $display("[TB] FAIL n16_i[%0d] got %0d want %0d", k, qc[k].i, br16[k] + 100); end
      checks++; if (qc[k].idx != br16[k]) begin errors++; $display("[TB] FAIL n16_idx[%0d] got %0d want %0d", k, qc[k].idx, br16[k]); end
      checks++; if (qc[k].last !== (k == 15)) begin errors++; $display("[TB] FAIL n16_last[%0d] got %0b want %0b", k, qc[k].last, k == 15); end
    end
`ifdef FFT_BITREV_FRAME_CHECK_EN
    checks++; if (frame_err_b !== 1'b0) begin errors++; $display("[TB] FAIL n2_frame_err got %0b want 0", frame_err_b); end
    checks++; if (frame_err_c !== 1'b0) begin errors++; $display("[TB] FAIL n16_frame_err got %0b want 0", frame_err_c); end
`endif
  endtask

`ifdef FFT_BITREV_FRAME_CHECK_EN
  task automatic test_frame_check();
    qa.delete();
    checks++; if (frame_err_a !== 1'b0) begin errors++; $display("[TB] FAIL ferr_initial got %0b want 0", frame_err_a); end
    last_pos = 5;
    applyStimulus(0, 64'd600, 6);
    checks++; if (frame_err_a !== 1'b1) begin errors++; $display("[TB] FAIL ferr_set got %0b want 1", frame_err_a); end
    last_pos = 7;
    applyStimulus(0, 64'd700, 8);
    wait_outputs(0, 16, 60);
    checks++; if (frame_err_a !== 1'b1) begin errors++; $display("[TB] FAIL ferr_sticky got %0b want 1", frame_err_a); end
    checks++; if (qa.size() != 16) begin errors++; $display("[TB] FAIL ferr_count got %0d want 16", qa.size()); end
    for (int k = 0; k < 8 && k + 8 < qa.size(); k++) begin
      checks++; if (qa[k + 8].r !== 64'(700 + br8[k])) begin errors++; $display("[TB] FAIL ferr_resync_r[%0d] got %0d want %0d", k, qa[k + 8].r, 700 + br8[k]); end
    end
  endtask
`endif

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    rst_n      = 1'b0;
    in_r       = '0;
    in_i       = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_valid_c = 1'b0;
    out_ready  = 1'b1;
    $display("[TB] starting fft_bitrev_buffer bench");
    test_reset();
    test_basic_order();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_small_sizes();
`ifdef FFT_BITREV_FRAME_CHECK_EN
    test_frame_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
